// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: arbitrates WB-stage exceptions, interrupts and ERET,
// and owns Cause, EPC, BadVAddr, Count and Compare (with the timer interrupt).
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter int unsigned CNT_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic        wb_has_exc,
  input  logic [4:0]  wb_excode,
  input  logic        wb_eret,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic [5:0]  hw_int,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic        exception,
  output logic        eret_flush,
  output logic [31:0] flush_pc,
  output logic [31:0] cause_data,
  output logic [31:0] epc_data,
  output logic [31:0] badvaddr_data,
  output logic [31:0] count_data,
  output logic [31:0] compare_data
);

  localparam int unsigned DivW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CNT_DIV - 1);

  localparam logic [5:0] AddrBadVAddr = 6'd8;
  localparam logic [5:0] AddrCount    = 6'd9;
  localparam logic [5:0] AddrCompare  = 6'd11;
  localparam logic [5:0] AddrCause    = 6'd13;
  localparam logic [5:0] AddrEpc      = 6'd14;

  typedef enum logic {StIdle, StFlush} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [5:0]      r_sync1;
  logic [5:0]      r_sync2;
  logic [1:0]      r_ip_sw;
  logic            r_ti;
  logic            r_bd;
  logic [4:0]      r_excode;
  logic [31:0]     r_epc;
  logic [31:0]     r_badvaddr;
  logic [31:0]     r_count;
  logic [31:0]     r_compare;
  logic [DivW-1:0] r_div;

  logic [7:0]      w_ip;
  logic            w_int_req;
  logic            w_take;
  logic            w_int_commit;
  logic            w_exc_commit;
  logic            w_eret_commit;
  logic            w_commit;
  logic            w_mtc0;
  logic            w_div_tick;
  logic            w_badv_code;

  assign w_ip      = {r_sync2[5] | r_ti, r_sync2[4:0], r_ip_sw};
  assign w_int_req = status_ie & ~status_exl & (|(w_ip & status_im));

  // rst_n gating keeps the commit pulses low while reset is held.
  assign w_take        = (r_state == StIdle) & wb_valid & rst_n;
  assign w_int_commit  = w_take & w_int_req;
  assign w_exc_commit  = w_take & ~w_int_req & wb_has_exc;
  assign w_eret_commit = w_take & ~w_int_req & ~wb_has_exc & wb_eret;
  assign w_commit      = w_int_commit | w_exc_commit | w_eret_commit;

  // An excepting instruction's MTC0 is cancelled, and nothing is written while squashing.
  assign w_mtc0      = mtc0_we & (r_state == StIdle) & ~w_commit;
  assign w_div_tick  = (r_div == DivMax);
  assign w_badv_code = (wb_excode == 5'd4) | (wb_excode == 5'd5);

  always_comb begin
    exception  = w_int_commit | w_exc_commit;
    eret_flush = w_eret_commit;
    flush_pc   = 32'h0;
    if (w_int_commit || w_exc_commit) begin
      flush_pc = EXC_ENTRY;
    end else if (w_eret_commit) begin
      flush_pc = r_epc;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_commit) w_state_next = StFlush;
      StFlush: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_ip_sw    <= '0;
      r_ti       <= 1'b0;
      r_bd       <= 1'b0;
      r_excode   <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_div      <= '0;
    end else begin
      r_state <= w_state_next;
      r_sync1 <= hw_int;
      r_sync2 <= r_sync1;

      if (w_mtc0 && cp0_addr == AddrCount) begin
        r_count <= mtc0_data;
        r_div   <= '0;
      end else begin
        r_div <= w_div_tick ? '0 : r_div + DivW'(1);
        if (w_div_tick) r_count <= r_count + 32'd1;
      end

      // Clearing TI on a Compare write takes priority over a same-cycle match.
      if (w_mtc0 && cp0_addr == AddrCompare) begin
        r_compare <= mtc0_data;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end

      if (w_mtc0 && cp0_addr == AddrCause) r_ip_sw <= mtc0_data[9:8];
      if (w_mtc0 && cp0_addr == AddrEpc)   r_epc   <= mtc0_data;

      if (w_int_commit || w_exc_commit) begin
        r_excode <= w_int_commit ? 5'd0 : wb_excode;
        if (!status_exl) begin
          r_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
          r_bd  <= wb_bd;
        end
        if (w_exc_commit && w_badv_code) r_badvaddr <= wb_badvaddr;
      end
    end
  end

  assign cause_data    = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_excode, 2'b0};
  assign epc_data      = r_epc;
  assign badvaddr_data = r_badvaddr;
  assign count_data    = r_count;
  assign compare_data  = r_compare;

  // BadVAddr is read-only to software; the address is decoded only to document that.
  logic w_unused_badv_wr;
  assign w_unused_badv_wr = mtc0_we & (cp0_addr == AddrBadVAddr);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: table-driven commit vectors with a commit-output scoreboard,
// plus hand sequences for reset, Count/Compare timing, synchroniser latency and reset-in-flush.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_has_exc, wb_eret, wb_bd;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic [5:0]  hw_int;
  logic        status_ie, status_exl;
  logic [7:0]  status_im;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        exception, eret_flush;
  logic [31:0] flush_pc, cause_data, epc_data, badvaddr_data, count_data, compare_data;

  localparam logic [31:0] Entry = 32'hBFC0_0380;

  cp0_exc_ctrl #(.EXC_ENTRY(Entry), .CNT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_has_exc(wb_has_exc), .wb_excode(wb_excode), .wb_eret(wb_eret),
    .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .hw_int(hw_int),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_data(mtc0_data),
    .exception(exception), .eret_flush(eret_flush), .flush_pc(flush_pc),
    .cause_data(cause_data), .epc_data(epc_data), .badvaddr_data(badvaddr_data),
    .count_data(count_data), .compare_data(compare_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        e;
    logic        r;
    logic [31:0] pc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [1:0]  sw;
    logic        ie, exl;
    logic [7:0]  im;
    logic        valid, has_exc;
    logic [4:0]  excode;
    logic        eret, bd;
    logic [31:0] pc, badv;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        x_exc, x_eret;
    logic [31:0] x_pc;
    logic [4:0]  x_code;
    logic [31:0] x_epc;
    logic        x_bd;
    logic [31:0] x_badv;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic e, input logic r, input logic [31:0] pc);
    sb_t s;
    s.e = e; s.r = r; s.pc = pc;
    sb_q.push_back(s);
  endtask

  task automatic sb_check(input string name);
    sb_t s;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      s = sb_q.pop_front();
      chk({name, "_exc"}, {31'b0, exception}, {31'b0, s.e});
      chk({name, "_eret"}, {31'b0, eret_flush}, {31'b0, s.r});
      if (s.e || s.r) chk({name, "_fpc"}, flush_pc, s.pc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    wb_valid = 0; wb_has_exc = 0; wb_excode = 0; wb_eret = 0; wb_bd = 0;
    wb_pc = 0; wb_badvaddr = 0; mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
  endtask

  task automatic mtc0(input logic [5:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_addr = a; mtc0_data = d;
    step();
    mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
  endtask

  task automatic chk_regs(input string name, input vec_t v);
    chk({name, "_code"}, {27'b0, cause_data[6:2]}, {27'b0, v.x_code});
    chk({name, "_bd"}, {31'b0, cause_data[31]}, {31'b0, v.x_bd});
    chk({name, "_epc"}, epc_data, v.x_epc);
    chk({name, "_badv"}, badvaddr_data, v.x_badv);
  endtask

  initial begin
    // name sw ie exl im | valid exc code eret bd pc badv | we addr data | expected
    vt[0]  = '{"novalid", 2'd1, 1, 0, 8'h01, 0, 1, 5'd8, 0, 0, 32'h0, 32'h1111_0000,
               0, 6'd0, 32'h0, 0, 0, 32'h0, 5'd0, 32'h0, 0, 32'h0};
    vt[1]  = '{"int_sw0", 2'd1, 1, 0, 8'h01, 1, 1, 5'd8, 1, 0, 32'h8000_0100, 32'h1111_0001,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd0, 32'h8000_0100, 0, 32'h0};
    vt[2]  = '{"exc_ie0", 2'd1, 0, 0, 8'h01, 1, 1, 5'd12, 0, 1, 32'h8000_0208, 32'h1111_0002,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd12, 32'h8000_0204, 1, 32'h0};
    vt[3]  = '{"eret_exl", 2'd1, 1, 1, 8'h01, 1, 0, 5'd0, 1, 0, 32'h0, 32'h1111_0003,
               0, 6'd0, 32'h0, 0, 1, 32'h8000_0204, 5'd12, 32'h8000_0204, 1, 32'h0};
    vt[4]  = '{"im_mask", 2'd2, 1, 0, 8'h01, 1, 1, 5'd10, 0, 0, 32'h8000_0300, 32'h1111_0004,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd10, 32'h8000_0300, 0, 32'h0};
    vt[5]  = '{"int_wrap", 2'd2, 1, 0, 8'h02, 1, 1, 5'd5, 0, 1, 32'h0, 32'h1111_0005,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd0, 32'hFFFF_FFFC, 1, 32'h0};
    vt[6]  = '{"eret", 2'd0, 1, 0, 8'hFF, 1, 0, 5'd0, 1, 0, 32'h0, 32'h1111_0006,
               0, 6'd0, 32'h0, 0, 1, 32'hFFFF_FFFC, 5'd0, 32'hFFFF_FFFC, 1, 32'h0};
    vt[7]  = '{"nop", 2'd0, 1, 0, 8'hFF, 1, 0, 5'd0, 0, 0, 32'h8000_0700, 32'h0,
               0, 6'd0, 32'h0, 0, 0, 32'h0, 5'd0, 32'hFFFF_FFFC, 1, 32'h0};
    vt[8]  = '{"adel_exl", 2'd0, 1, 1, 8'h00, 1, 1, 5'd4, 0, 0, 32'h8000_0400, 32'hCAFE_F00D,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd4, 32'hFFFF_FFFC, 1, 32'hCAFE_F00D};
    vt[9]  = '{"sys_bd", 2'd0, 1, 0, 8'h00, 1, 1, 5'd8, 0, 1, 32'h8000_1004, 32'h0,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd8, 32'h8000_1000, 1, 32'hCAFE_F00D};
    vt[10] = '{"sys_exl", 2'd0, 1, 1, 8'h00, 1, 1, 5'd8, 0, 0, 32'h8000_2000, 32'h0,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd8, 32'h8000_1000, 1, 32'hCAFE_F00D};
    vt[11] = '{"adel_mtc0", 2'd0, 1, 0, 8'h00, 1, 1, 5'd4, 0, 0, 32'h8000_3000, 32'h1234_5671,
               1, 6'd14, 32'hDEAD_0000, 1, 0, Entry, 5'd4, 32'h8000_3000, 0, 32'h1234_5671};
    vt[12] = '{"mtc0_epc", 2'd0, 1, 0, 8'h00, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0,
               1, 6'd14, 32'h8000_2000, 0, 0, 32'h0, 5'd4, 32'h8000_2000, 0, 32'h1234_5671};
    vt[13] = '{"eret2", 2'd0, 1, 0, 8'h00, 1, 0, 5'd0, 1, 0, 32'h0, 32'h0,
               0, 6'd0, 32'h0, 0, 1, 32'h8000_2000, 5'd4, 32'h8000_2000, 0, 32'h1234_5671};
    vt[14] = '{"mtc0_badv", 2'd0, 1, 0, 8'h00, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0,
               1, 6'd8, 32'hFFFF_FFFF, 0, 0, 32'h0, 5'd4, 32'h8000_2000, 0, 32'h1234_5671};
    vt[15] = '{"ades", 2'd0, 1, 0, 8'h00, 1, 1, 5'd5, 0, 0, 32'h8000_4000, 32'h0000_0ABC,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd5, 32'h8000_4000, 0, 32'h0000_0ABC};
    vt[16] = '{"ov_nobadv", 2'd0, 1, 0, 8'h00, 1, 1, 5'd12, 0, 0, 32'h8000_5000, 32'h9999_9999,
               0, 6'd0, 32'h0, 1, 0, Entry, 5'd12, 32'h8000_5000, 0, 32'h0000_0ABC};

    rst_n = 0; hw_int = 0; status_ie = 0; status_exl = 0; status_im = 0;
    clr_in();

    // Reset state
    repeat (3) step();
    chk("rst_exc", {31'b0, exception}, 32'h0);
    chk("rst_eret", {31'b0, eret_flush}, 32'h0);
    chk("rst_fpc", flush_pc, 32'h0);
    chk("rst_cause", cause_data, 32'h0);
    chk("rst_epc", epc_data, 32'h0);
    chk("rst_badv", badvaddr_data, 32'h0);
    chk("rst_count", count_data, 32'h0);
    chk("rst_compare", compare_data, 32'h0);
    rst_n = 1;
    repeat (10) step();
    chk("count_div", count_data, 32'd5);

    // Count wrap, no spurious TI
    mtc0(6'd11, 32'h10);
    chk("compare_wr", compare_data, 32'h10);
    chk("ti_cleared", {31'b0, cause_data[30]}, 32'h0);
    mtc0(6'd9, 32'hFFFF_FFFF);
    chk("count_load", count_data, 32'hFFFF_FFFF);
    step();
    chk("count_hold", count_data, 32'hFFFF_FFFF);
    step();
    chk("count_wrap", count_data, 32'h0);
    chk("wrap_no_ti", {31'b0, cause_data[30]}, 32'h0);
    mtc0(6'd11, 32'hFFFF_0000);

    // Commit table
    for (int i = 0; i < 17; i++) begin
      mtc0(6'd13, {22'b0, vt[i].sw, 8'b0});
      status_ie = vt[i].ie; status_exl = vt[i].exl; status_im = vt[i].im;
      wb_valid = vt[i].valid; wb_has_exc = vt[i].has_exc; wb_excode = vt[i].excode;
      wb_eret = vt[i].eret; wb_bd = vt[i].bd; wb_pc = vt[i].pc; wb_badvaddr = vt[i].badv;
      mtc0_we = vt[i].we; cp0_addr = vt[i].addr; mtc0_data = vt[i].wdata;
      sb_push(vt[i].x_exc, vt[i].x_eret, vt[i].x_pc);
      #1;
      sb_check(vt[i].name);
      step();
      // Inputs still held: a committed instruction's FLUSH cycle must ignore them.
      if (vt[i].x_exc || vt[i].x_eret) begin
        chk({vt[i].name, "_flush_exc"}, {31'b0, exception}, 32'h0);
        chk({vt[i].name, "_flush_eret"}, {31'b0, eret_flush}, 32'h0);
      end
      chk_regs(vt[i].name, vt[i]);
      step();
      chk_regs({vt[i].name, "_late"}, vt[i]);
      clr_in();
    end

    // ERET followed by an exception during FLUSH
    status_ie = 0; status_exl = 0; status_im = 0;
    wb_valid = 1; wb_eret = 1;
    sb_push(0, 1, 32'h8000_5000);
    #1;
    sb_check("eret_seq");
    step();
    wb_eret = 0; wb_has_exc = 1; wb_excode = 5'd8; wb_pc = 32'h8000_6000;
    mtc0_we = 1; cp0_addr = 6'd14; mtc0_data = 32'h1;
    #1;
    chk("flush_ign_exc", {31'b0, exception}, 32'h0);
    step();
    chk("flush_ign_mtc0", epc_data, 32'h8000_5000);
    chk("flush_ign_code", {27'b0, cause_data[6:2]}, 32'd12);
    clr_in();
    step();

    // Timer interrupt
    mtc0(6'd13, 32'h0);
    status_ie = 1; status_exl = 0; status_im = 8'h80;
    mtc0(6'd11, 32'd8);
    mtc0(6'd9, 32'd0);
    for (int i = 0; i < 64; i++) begin
      if (cause_data[30]) break;
      step();
    end
    chk("ti_set", {31'b0, cause_data[30]}, 32'h1);
    chk("ti_count", count_data, 32'd8);
    chk("ti_ip7", {31'b0, cause_data[15]}, 32'h1);
    wb_valid = 1; wb_pc = 32'hBFC0_0100;
    sb_push(1, 0, Entry);
    #1;
    sb_check("timer_int");
    step();
    chk("timer_flush", {31'b0, exception}, 32'h0);
    chk("timer_code", {27'b0, cause_data[6:2]}, 32'h0);
    chk("timer_epc", epc_data, 32'hBFC0_0100);
    clr_in();
    step();
    mtc0(6'd11, 32'hFFFF_0000);
    chk("ti_clear", {31'b0, cause_data[30]}, 32'h0);
    chk("ip7_clear", {31'b0, cause_data[15]}, 32'h0);

    // hw_int two-stage synchroniser
    status_im = 0;
    hw_int = 6'b100000;
    step();
    chk("sync_1", {31'b0, cause_data[15]}, 32'h0);
    step();
    chk("sync_2", {31'b0, cause_data[15]}, 32'h1);
    hw_int = 6'b000100;
    step(); step();
    chk("sync_ip4", {24'b0, cause_data[15:8]}, 32'h10);
    hw_int = 0;
    step(); step();

    // Reset during FLUSH
    status_ie = 0;
    wb_valid = 1; wb_has_exc = 1; wb_excode = 5'd8; wb_pc = 32'h8000_7000;
    sb_push(1, 0, Entry);
    #1;
    sb_check("pre_rst");
    step();
    rst_n = 0;
    step();
    chk("rstf_exc", {31'b0, exception}, 32'h0);
    chk("rstf_epc", epc_data, 32'h0);
    chk("rstf_cause", cause_data, 32'h0);
    chk("rstf_count", count_data, 32'h0);
    rst_n = 1;
    sb_push(1, 0, Entry);
    #1;
    sb_check("post_rst_idle");
    clr_in();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception and interrupt control for CP0. The block sits between the WB stage and the CP0 Status register. It detects interrupts and pipeline exceptions, arbitrates between them, and generates the one-cycle `exception` and `eret_flush` pulses that Status consumes. It also owns Cause, EPC, BadVAddr, Count and Compare (with the timer interrupt) and supplies the redirect PC to fetch.

Parameters:
EXC_ENTRY, 32'hBFC0_0380, exception vector driven on flush_pc.
CNT_DIV, 2, clock cycles per Count increment (power of 2, at least 1).

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
wb_valid  in  1  valid instruction in WB
wb_has_exc  in  1  WB instruction raised a synchronous exception
wb_excode  in  5  ExcCode of that exception
wb_eret  in  1  WB instruction is ERET
wb_bd  in  1  WB instruction is in a branch delay slot
wb_pc  in  32  WB instruction PC
wb_badvaddr  in  32  faulting address for AdEL/AdES
hw_int  in  6  external interrupt lines (asynchronous, level)
status_ie  in  1  Status.IE
status_exl  in  1  Status.EXL
status_im  in  8  Status.IM[7:0]
mtc0_we  in  1  MTC0 write strobe from WB
cp0_addr  in  6  CP0 register number: 8 BadVAddr, 9 Count, 11 Compare, 13 Cause, 14 EPC
mtc0_data  in  32  MTC0 write data
exception  out  1  one-cycle exception commit pulse
eret_flush  out  1  one-cycle ERET commit pulse
flush_pc  out  32  redirect target, valid while exception or eret_flush is high
cause_data  out  32  Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2], all other bits 0
epc_data  out  32  EPC
badvaddr_data  out  32  BadVAddr
count_data  out  32  Count
compare_data  out  32  Compare

Behaviour:
- Reset (rst_n=0 at a clk edge): Cause, EPC, BadVAddr, Count and Compare are all 0. Divider is 0. hw_int sync flops are 0. State is IDLE. exception=0, eret_flush=0, flush_pc=0.
- hw_int synchronisation:
  - Two flop stages; Cause.IP[7:2] follows the second stage.
  - IP[7] = sync hw_int[5] OR TI.
  - IP[1:0] are writable only by MTC0 to Cause. Besides IP[1:0], MTC0 to Cause writes nothing else.
- Interrupt condition: int_req = status_ie & ~status_exl & |(IP & status_im).
- Commit logic (combinational, evaluated only in IDLE and when wb_valid=1):
  - Priority is int_req, then wb_has_exc, then wb_eret.
  - Interrupt or exception: exception=1, flush_pc=EXC_ENTRY.
  - ERET: eret_flush=1, flush_pc=epc_data.
  - exception and eret_flush are never high together.
- State machine:
  - IDLE goes to FLUSH on any commit.
  - FLUSH goes back to IDLE after exactly one cycle.
  - In FLUSH, all WB inputs and mtc0_we are ignored, because the pipeline is being squashed.
- Register updates on an exception commit:
  - ExcCode <= 0 for an interrupt, otherwise wb_excode.
  - If status_exl=0: EPC <= wb_bd ? wb_pc-4 : wb_pc (mod 2^32), and BD <= wb_bd.
  - If status_exl=1: EPC and BD are unchanged.
  - BadVAddr <= wb_badvaddr when the exception is not an interrupt and wb_excode is 4 or 5.
- MTC0:
  - Takes effect only when no commit happens in the same cycle; an excepting instruction's MTC0 is cancelled.
  - Writes to BadVAddr are ignored.
- Count:
  - Free-running divider; Count increments when the divider reaches CNT_DIV-1. Wraps 0xFFFFFFFF to 0.
  - MTC0 Count loads mtc0_data and clears the divider.
- Compare:
  - MTC0 Compare loads mtc0_data and clears TI.
  - TI is set in a cycle where Count==Compare (current register values) and Compare is not being written; it stays set until the next Compare write.
  - Clearing TI wins over setting it in the same cycle.
- Reset mid-FLUSH returns to IDLE with all registers cleared.

Test Plan:
1. Reset, then read all outputs -> all 0. Hold 10 cycles with CNT_DIV=2 -> count_data=5.
2. MTC0 Count=0xFFFFFFFF -> count_data=0 two cycles later, with no spurious TI (Compare=0x10).
3. Compare=8, Count=0, ie=1, exl=0, im=0x80; wait until Count==8 -> cause_data[30]=1, IP7=1. Next WB valid at pc 0xBFC0_0100 -> exception=1 for 1 cycle, ExcCode=0, EPC=0xBFC0_0100, flush_pc=0xBFC0_0380. MTC0 Compare then clears TI.
4. Syscall in a delay slot: wb_excode=8, bd=1, pc=0x8000_1004, exl=0 -> EPC=0x8000_1000, BD=1, ExcCode=8. Repeat with exl=1 and pc=0x8000_2000 -> EPC and BD unchanged, ExcCode=8.
5. AdEL with wb_badvaddr=0x1234_5671 -> BadVAddr=0x1234_5671. Same-cycle MTC0 to EPC with data 0xDEAD_0000 -> EPC gets the exception value instead.
6. EPC=0x8000_2000, wb_eret=1 -> eret_flush=1 for 1 cycle with flush_pc=0x8000_2000. A wb_has_exc=1 in the following cycle -> ignored (FLUSH), exception stays 0.
